// File: rtl/wb_mem_responder_if.sv
// Wishbone-classic bus bundle between a SERV ibus/dbus master and wb_mem_responder.
// The master drives the request fields; the responder drives rdt/ack.
interface wb_mem_responder_if;
  logic        i_cyc;
  logic [31:0] i_adr;
  logic [31:0] i_dat;
  logic [3:0]  i_sel;
  logic        i_we;
  logic [31:0] o_rdt;
  logic        o_ack;

  modport slave  (input  i_cyc, i_adr, i_dat, i_sel, i_we, output o_rdt, o_ack);
  modport master (output i_cyc, i_adr, i_dat, i_sel, i_we, input  o_rdt, o_ack);
endinterface

// File: rtl/wb_mem_responder.sv
// Bounded-latency Wishbone-classic word RAM that answers one SERV bus and counts transfers.
// Optional pseudo-random extra wait states when WB_RESP_LFSR_STALL_EN is defined.
module wb_mem_responder #(
  parameter int unsigned AW        = 6,
  parameter int unsigned LATENCY   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  wb_mem_responder_if.slave     bus,
  output logic                  o_oob,
  output logic [15:0]           o_xfer_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  localparam int unsigned WORDS = 1 << AW;

  logic [31:0]   mem [WORDS];

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] word_q, word_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          far_q, far_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdt_q, rdt_d;
  logic          oob_q, oob_d;
  logic [15:0]   xfer_q, xfer_d;
  logic [3:0]    wait_n;
  logic          in_range;
  logic          unused_adr;

  assign in_range   = (bus.i_adr[31:AW+2] == '0);
  assign unused_adr = ^bus.i_adr[1:0];

`ifdef WB_RESP_LFSR_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  // Fibonacci taps 16,14,13,11; the value before stepping picks this request's extra waits.
  assign wait_n = 4'(LATENCY) + {2'b00, lfsr_q[1:0]};
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == S_IDLE && bus.i_cyc)
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign wait_n      = 4'(LATENCY);
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    far_d   = far_q;
    oob_d   = oob_q;
    xfer_d  = xfer_q;
    unique case (state_q)
      S_IDLE: if (bus.i_cyc) begin
        word_d = bus.i_adr[AW+1:2];
        dat_d  = bus.i_dat;
        sel_d  = bus.i_sel;
        we_d   = bus.i_we;
        far_d  = !in_range;
        // Counter holds the remaining waits after the current one, so N waits end on 0.
        if (wait_n == 4'd0) state_d = S_ACK;
        else begin
          state_d = S_WAIT;
          cnt_d   = wait_n - 4'd1;
        end
      end
      S_WAIT: begin
        if (!bus.i_cyc)          state_d = S_IDLE;
        else if (cnt_q == 4'd0)  state_d = S_ACK;
        else                     cnt_d   = cnt_q - 4'd1;
      end
      S_ACK: begin
        state_d = S_IDLE;
        if (xfer_q != 16'hFFFF) xfer_d = xfer_q + 16'd1;
        if (far_q)              oob_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    ack_d = (state_d == S_ACK);
    rdt_d = '0;
    if (ack_d && !we_d && !far_d) rdt_d = mem[word_d];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      far_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdt_q   <= '0;
      oob_q   <= 1'b0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      far_q   <= far_d;
      ack_q   <= ack_d;
      rdt_q   <= rdt_d;
      oob_q   <= oob_d;
      xfer_q  <= xfer_d;
    end
  end

  // NOTE: the RAM array has no reset; contents are undefined until written.
  always_ff @(posedge clock) begin
    if (state_q == S_ACK && we_q && !far_q) begin
      for (int k = 0; k < 4; k++)
        if (sel_q[k]) mem[word_q][8*k +: 8] <= dat_q[8*k +: 8];
    end
  end

  assign bus.o_ack  = ack_q;
  assign bus.o_rdt  = rdt_q;
  assign o_oob      = oob_q;
  assign o_xfer_cnt = xfer_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed self-checking bench for wb_mem_responder (AW=6, LATENCY=2).
// With WB_RESP_LFSR_STALL_EN defined, expected wait counts come from a bench LFSR model.
module tb_wb_mem_responder;
  localparam int unsigned LATENCY = 2;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        o_oob;
  logic [15:0] o_xfer_cnt;
  logic [31:0] r;
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_cnt  = 0;
  int          n_acks;
  int          dummy_n;

  wb_mem_responder_if bus ();

  wb_mem_responder #(.AW(6), .LATENCY(LATENCY), .LFSR_SEED(SEED)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .o_oob      (o_oob),
    .o_xfer_cnt (o_xfer_cnt)
  );

  always #5 clock = ~clock;

`ifdef WB_RESP_LFSR_STALL_EN
  logic [15:0] m_lfsr = SEED;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected wait count for the next accepted request.
  task automatic next_wait(output int n);
`ifdef WB_RESP_LFSR_STALL_EN
    n      = int'(LATENCY) + int'(m_lfsr[1:0]);
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`else
    n = int'(LATENCY);
`endif
  endtask

  task automatic model_reset();
`ifdef WB_RESP_LFSR_STALL_EN
    m_lfsr = SEED;
`endif
    exp_cnt = 0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge in the cycle after ACK.
  task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel, output logic [31:0] rdt);
    int n, cyc_n, bad;
    bit seen;
    next_wait(n);
    bus.i_cyc = 1'b1; bus.i_we = we; bus.i_adr = adr; bus.i_dat = dat; bus.i_sel = sel;
    cyc_n = 1; bad = 0; seen = 1'b0; rdt = '0;
    while (!seen && cyc_n < 24) begin
      @(posedge clock); @(negedge clock);
      cyc_n++;
      if (bus.o_ack) begin
        seen = 1'b1; rdt = bus.o_rdt; bus.i_cyc = 1'b0;
      end else begin
        if (bus.o_rdt !== 32'h0) bad++;
        // Request fields wobble during WAIT; only the latched copy may matter.
        bus.i_adr = adr ^ 32'h4; bus.i_dat = ~dat; bus.i_sel = ~sel;
      end
    end
    bus.i_cyc = 1'b0;
    check({tag, "_ack_cycle"}, cyc_n, n + 2);
    check({tag, "_rdt_idle"}, bad, 0);
    if (we) check({tag, "_wr_rdt"}, rdt, 32'h0);
    if (seen && exp_cnt < 65535) exp_cnt++;
    @(posedge clock); @(negedge clock);
    check({tag, "_ack_pulse"}, bus.o_ack, 1'b0);
    check({tag, "_cnt"}, o_xfer_cnt, exp_cnt);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.i_cyc = 1'b0; bus.i_we = 1'b0; bus.i_adr = '0; bus.i_dat = '0; bus.i_sel = '0;
    repeat (2) @(negedge clock);
    check("rst_ack", bus.o_ack, 1'b0);
    check("rst_rdt", bus.o_rdt, 32'h0);
    check("rst_oob", o_oob, 1'b0);
    check("rst_cnt", o_xfer_cnt, 16'h0);
    reset_n = 1'b1;
    @(negedge clock);

    xfer("t1_wr", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r);
    xfer("t2_rd", 1'b0, 32'h10, 32'h0, 4'h0, r);
    check("t2_data", r, 32'hDEADBEEF);

    xfer("t3_wr", 1'b1, 32'h10, 32'h11223344, 4'b0101, r);
    xfer("t3_rd", 1'b0, 32'h13, 32'h0, 4'h0, r);
    check("t3_data", r, 32'hDE22BE44);

    xfer("sel0_wr", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, r);
    xfer("sel0_rd", 1'b0, 32'h10, 32'h0, 4'h0, r);
    check("sel0_data", r, 32'hDE22BE44);

    xfer("t4_oob_wr", 1'b1, 32'h0000_1010, 32'h55555555, 4'hF, r);
    check("t4_oob_set", o_oob, 1'b1);
    xfer("t4_oob_rd", 1'b0, 32'h0000_1000, 32'h0, 4'h0, r);
    check("t4_oob_data", r, 32'h0);
    xfer("t4_alias_rd", 1'b0, 32'h10, 32'h0, 4'h0, r);
    check("t4_alias_data", r, 32'hDE22BE44);
    check("t4_oob_sticky", o_oob, 1'b1);

    // Abort: request accepted, then i_cyc drops in the first WAIT cycle.
    next_wait(dummy_n);
    bus.i_cyc = 1'b1; bus.i_we = 1'b1; bus.i_adr = 32'h10; bus.i_dat = 32'hCAFEF00D; bus.i_sel = 4'hF;
    @(posedge clock); @(negedge clock);
    bus.i_cyc = 1'b0;
    n_acks = 0;
    repeat (10) begin
      @(posedge clock); @(negedge clock);
      if (bus.o_ack) n_acks++;
    end
    check("t5_no_ack", n_acks, 0);
    check("t5_cnt", o_xfer_cnt, exp_cnt);
    xfer("t5_rd", 1'b0, 32'h10, 32'h0, 4'h0, r);
    check("t5_data", r, 32'hDE22BE44);

    // Reset while a write waits.
    next_wait(dummy_n);
    bus.i_cyc = 1'b1; bus.i_we = 1'b1; bus.i_adr = 32'h14; bus.i_dat = 32'h12345678; bus.i_sel = 4'hF;
    @(posedge clock); @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("t6_ack", bus.o_ack, 1'b0);
    check("t6_cnt", o_xfer_cnt, 16'h0);
    check("t6_oob_clr", o_oob, 1'b0);
    bus.i_cyc = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    n_acks = 0;
    repeat (8) begin
      @(posedge clock); @(negedge clock);
      if (bus.o_ack) n_acks++;
    end
    check("t6_no_ack", n_acks, 0);
    for (int i = 0; i < 8; i++) xfer($sformatf("t6_rd%0d", i), 1'b0, 32'h10, 32'h0, 4'h0, r);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
